// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants for seven-segment pattern checkers.
//               Active-low segment codes (bit0=a .. bit6=g), blank code and
//               the 2-bit capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Active-low codes for hex digits 0..F
  localparam logic [6:0] SEG_CODE_0 = 7'h40;
  localparam logic [6:0] SEG_CODE_1 = 7'h79;
  localparam logic [6:0] SEG_CODE_2 = 7'h24;
  localparam logic [6:0] SEG_CODE_3 = 7'h30;
  localparam logic [6:0] SEG_CODE_4 = 7'h19;
  localparam logic [6:0] SEG_CODE_5 = 7'h12;
  localparam logic [6:0] SEG_CODE_6 = 7'h02;
  localparam logic [6:0] SEG_CODE_7 = 7'h78;
  localparam logic [6:0] SEG_CODE_8 = 7'h00;
  localparam logic [6:0] SEG_CODE_9 = 7'h10;
  localparam logic [6:0] SEG_CODE_A = 7'h08;
  localparam logic [6:0] SEG_CODE_B = 7'h03;
  localparam logic [6:0] SEG_CODE_C = 7'h46;
  localparam logic [6:0] SEG_CODE_D = 7'h21;
  localparam logic [6:0] SEG_CODE_E = 7'h06;
  localparam logic [6:0] SEG_CODE_F = 7'h0E;

  // All segments dark
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  // Capture FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_pattern_lookup.sv
`default_nettype none
// ============================================================================
// Module      : seg_pattern_lookup
// Description : Combinational decode of a 7-bit active-low segment pattern
//               into {hit, blank, digit}. hit=1 for a legal hex code,
//               blank=1 for the all-dark pattern, neither for anything else.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic       blank,
  output logic [3:0] digit
);

  // Reverse table: pattern -> digit
  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    digit = 4'h0;
    case (pattern)
      SEG_CODE_0: digit = 4'h0;
      SEG_CODE_1: digit = 4'h1;
      SEG_CODE_2: digit = 4'h2;
      SEG_CODE_3: digit = 4'h3;
      SEG_CODE_4: digit = 4'h4;
      SEG_CODE_5: digit = 4'h5;
      SEG_CODE_6: digit = 4'h6;
      SEG_CODE_7: digit = 4'h7;
      SEG_CODE_8: digit = 4'h8;
      SEG_CODE_9: digit = 4'h9;
      SEG_CODE_A: digit = 4'hA;
      SEG_CODE_B: digit = 4'hB;
      SEG_CODE_C: digit = 4'hC;
      SEG_CODE_D: digit = 4'hD;
      SEG_CODE_E: digit = 4'hE;
      SEG_CODE_F: digit = 4'hF;
      SEG_BLANK: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

endmodule : seg_pattern_lookup
`default_nettype wire

// File: rtl/seg_pattern_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg_pattern_capture
// Description : Recovers hex digits from debounced seven-segment patterns and
//               shifts them into a NUM_DIGITS-nibble value register.
//               Build option: define SEG_ACTIVE_HIGH_EN for active-high
//               seg_in (inverted on entry; blank is then input 7'h00).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pattern_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  input  logic                    clear,
  output logic [3:0]              digit_out,
  output logic                    digit_valid,
  output logic                    digit_blank,
  output logic                    digit_error,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_ready
);

  localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);
  localparam logic [3:0] c_num    = 4'(NUM_DIGITS);
  // A freshly latched pattern already satisfies a one-sample requirement
  localparam logic [1:0] c_after_latch = (STABLE_CYCLES == 1) ? ST_EMIT : ST_SETTLE;

  logic [1:0]              r_state;
  logic [7:0]              r_count;
  logic [6:0]              r_pattern;
  logic [3:0]              r_digit;
  logic                    r_digit_valid;
  logic                    r_digit_blank;
  logic                    r_digit_error;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [3:0]              r_num;

  logic [6:0]              w_seg;
  logic                    w_match;
  logic [7:0]              w_next_count;
  logic                    w_hit;
  logic                    w_blank;
  logic [3:0]              w_lut_digit;
  logic [4*NUM_DIGITS-1:0] w_shifted;

  // Normalise the input to active-low so all compares use one polarity
`ifdef SEG_ACTIVE_HIGH_EN
  assign w_seg = ~seg_in;
`else
  assign w_seg = seg_in;
`endif

  assign w_match      = (w_seg == r_pattern);
  assign w_next_count = r_count + 8'd1;

  seg_pattern_lookup u_lookup (
    .pattern (r_pattern),
    .hit     (w_hit),
    .blank   (w_blank),
    .digit   (w_lut_digit)
  );

  generate
    if (NUM_DIGITS == 1) begin : g_single
      assign w_shifted = r_digit;
    end else begin : g_multi
      assign w_shifted = {r_value[4*NUM_DIGITS-5:0], r_digit};
    end
  endgenerate

  // Stability FSM: latch, count matching samples, emit once per stable pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_count       <= 8'd0;
      r_pattern     <= SEG_BLANK;
      r_digit       <= 4'h0;
      r_digit_valid <= 1'b0;
      r_digit_blank <= 1'b0;
      r_digit_error <= 1'b0;
    end else begin
      r_digit_valid <= 1'b0;
      r_digit_blank <= 1'b0;
      r_digit_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (seg_valid) begin
            r_pattern <= w_seg;
            r_count   <= 8'd1;
            r_state   <= c_after_latch;
          end
        end
        ST_SETTLE: begin
          if (!seg_valid) begin
            r_count <= 8'd0;
            r_state <= ST_IDLE;
          end else if (w_match) begin
            r_count <= w_next_count;
            if (w_next_count >= c_stable) begin
              r_state <= ST_EMIT;
            end
          end else begin
            r_pattern <= w_seg;
            r_count   <= 8'd1;
            r_state   <= c_after_latch;
          end
        end
        ST_EMIT: begin
          if (w_hit) begin
            r_digit       <= w_lut_digit;
            r_digit_valid <= 1'b1;
          end else if (w_blank) begin
            r_digit_blank <= 1'b1;
          end else begin
            r_digit_error <= 1'b1;
          end
          r_state <= ST_HOLD;
        end
        default: begin // ST_HOLD
          if (!seg_valid) begin
            r_count <= 8'd0;
            r_state <= ST_IDLE;
          end else if (!w_match) begin
            r_pattern <= w_seg;
            r_count   <= 8'd1;
            r_state   <= c_after_latch;
          end
        end
      endcase
    end
  end

  // Shift the reported digit into the value register; clear takes priority
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_value <= '0;
      r_num   <= 4'd0;
    end else if (r_digit_valid) begin
      r_value <= w_shifted;
      if (r_num != c_num) begin
        r_num <= r_num + 4'd1;
      end
    end
  end

  assign digit_out   = r_digit;
  assign digit_valid = r_digit_valid;
  assign digit_blank = r_digit_blank;
  assign digit_error = r_digit_error;
  assign value_out   = r_value;
  assign value_ready = (r_num == c_num);

endmodule : seg_pattern_capture
`default_nettype wire

// File: tb/tb_seg_pattern_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_pattern_capture
// Description : Scoreboard bench for seg_pattern_capture with default
//               parameters (NUM_DIGITS=4, STABLE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_pattern_capture;

  localparam logic [1:0] c_k_valid = 2'd0;
  localparam logic [1:0] c_k_blank = 2'd1;
  localparam logic [1:0] c_k_error = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [3:0] digit;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        clear;
  logic [3:0]  digit_out;
  logic        digit_valid;
  logic        digit_blank;
  logic        digit_error;
  logic [15:0] value_out;
  logic        value_ready;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  seg_pattern_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .clear       (clear),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .digit_error (digit_error),
    .value_out   (value_out),
    .value_ready (value_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] digit);
    exp_t e;
    e.kind  = kind;
    e.digit = digit;
    sb.push_back(e);
  endtask

  // Drive one sample, then advance past the edge that consumes it
  task automatic step(input logic v, input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      seg_valid = v;
      seg_in    = p;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && (digit_valid || digit_blank || digit_error)) begin
      n_vec++;
      if ((digit_valid + digit_blank + digit_error) != 2'd1) begin
        n_err++;
        $display("FAIL pulse_onehot: got v=%b b=%b e=%b expected exactly one",
                 digit_valid, digit_blank, digit_error);
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got v=%b b=%b e=%b digit=%h expected none",
                 digit_valid, digit_blank, digit_error, digit_out);
      end else begin
        exp_t e;
        logic [1:0] k;
        e = sb.pop_front();
        k = digit_valid ? c_k_valid : (digit_blank ? c_k_blank : c_k_error);
        if (k != e.kind || (digit_valid && digit_out != e.digit)) begin
          n_err++;
          $display("FAIL pulse: got kind=%0d digit=%h expected kind=%0d digit=%h",
                   k, digit_out, e.kind, e.digit);
        end
      end
    end
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    seg_valid = 1'b0;
    seg_in    = 7'h7F;
    step(1'b0, 7'h7F, 3);
    reset = 1'b0;
    step(1'b0, 7'h7F, 1);

    // Reset state
    check("rst_value", value_out, 32'h0);
    check("rst_ready", value_ready, 32'h0);
    check("rst_digit", digit_out, 32'h0);
    check("rst_pulses", {digit_valid, digit_blank, digit_error}, 32'h0);

    // 1,2,3,4 back to back, six samples each
    push(c_k_valid, 4'h1); step(1'b1, 7'h79, 6);
    push(c_k_valid, 4'h2); step(1'b1, 7'h24, 6);
    push(c_k_valid, 4'h3); step(1'b1, 7'h30, 6);
    check("ready_before_4th", value_ready, 32'h0);
    push(c_k_valid, 4'h4); step(1'b1, 7'h19, 6);
    check("value_1234", value_out, 32'h1234);
    check("ready_after_4th", value_ready, 32'h1);
    step(1'b0, 7'h7F, 1);

    // Glitch: 0 seen only three times, then 1 stable
    push(c_k_valid, 4'h1);
    step(1'b1, 7'h40, 3);
    step(1'b1, 7'h79, 5);
    step(1'b0, 7'h7F, 2);
    check("value_glitch", value_out, 32'h2341);
    check("ready_stays", value_ready, 32'h1);

    // Long hold captures once; re-present after a gap captures again
    push(c_k_valid, 4'hA);
    step(1'b1, 7'h08, 50);
    step(1'b0, 7'h7F, 1);
    check("value_hold", value_out, 32'h341A);
    push(c_k_valid, 4'hA);
    step(1'b1, 7'h08, 4);
    step(1'b0, 7'h7F, 3);
    check("value_hold2", value_out, 32'h41AA);

    // Illegal and blank patterns do not shift
    push(c_k_error, 4'h0);
    step(1'b1, 7'h55, 4);
    step(1'b0, 7'h7F, 3);
    check("value_after_err", value_out, 32'h41AA);
    push(c_k_blank, 4'h0);
    step(1'b1, 7'h7F, 4);
    step(1'b0, 7'h7F, 3);
    check("value_after_blank", value_out, 32'h41AA);
    check("digit_held", digit_out, 32'hA);

    // Clear in the same cycle digit_valid for E is shown
    push(c_k_valid, 4'hE);
    step(1'b1, 7'h06, 5);
    check("pulse_e_visible", digit_valid, 32'h1);
    clear = 1'b1;
    step(1'b1, 7'h06, 1);
    clear = 1'b0;
    check("clear_value", value_out, 32'h0);
    check("clear_ready", value_ready, 32'h0);
    check("clear_digit", digit_out, 32'hE);
    step(1'b0, 7'h7F, 1);
    push(c_k_valid, 4'h3);
    step(1'b1, 7'h30, 4);
    step(1'b0, 7'h7F, 2);
    check("count_restart", value_out, 32'h0003);
    check("count_restart_ready", value_ready, 32'h0);

    // Reset while settling (three matching samples) emits nothing
    step(1'b1, 7'h12, 3);
    reset = 1'b1;
    step(1'b1, 7'h12, 1);
    reset = 1'b0;
    check("midrst_value", value_out, 32'h0);
    check("midrst_digit", digit_out, 32'h0);
    step(1'b0, 7'h7F, 2);
    push(c_k_valid, 4'h5);
    step(1'b1, 7'h12, 4);
    step(1'b0, 7'h7F, 3);
    check("after_rst_value", value_out, 32'h0005);
    check("after_rst_digit", digit_out, 32'h5);

    step(1'b0, 7'h7F, 4);
    check("sb_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seg_pattern_capture
`default_nettype wire
